// File: rtl/gfx_cmd_pkg.sv
// Opcode map, trigger-argument lookup and status bit positions shared by the
// command queue and anything that decodes its status register.
package gfx_cmd_pkg;

  localparam logic [7:0] OP_PUTC  = 8'h00;  // char, attr      -> trigger arg1
  localparam logic [7:0] OP_CLEAR = 8'h01;  // fill colour     -> trigger arg0
  localparam logic [7:0] OP_PIXEL = 8'h02;  // x, y, colour    -> trigger arg2
  localparam logic [7:0] OP_LINE  = 8'h03;  // x0,y0,x1,y1,c   -> trigger arg4
  localparam logic [7:0] OP_RECT  = 8'h04;  // x,y,w,h,c       -> trigger arg4
  localparam logic [7:0] OP_BLIT  = 8'h05;  // 11 args         -> trigger arg10

  // First argument register address
  localparam int ARG_BASE = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_ERROR    = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_FULL     = 3;
  localparam int ST_IRQ      = 4;
  localparam int ST_READY    = 7;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT} issue_state_e;

  function automatic logic opcode_valid(input logic [7:0] op);
    return op <= OP_BLIT;
  endfunction

  // Register address whose write snapshots the command. Unknown opcodes map
  // to arg0 so that the CPU's usual first arg write flags the error.
  function automatic logic [7:0] trigger_idx(input logic [7:0] op);
    case (op)
      OP_PUTC:  return 8'(ARG_BASE + 1);
      OP_CLEAR: return 8'(ARG_BASE + 0);
      OP_PIXEL: return 8'(ARG_BASE + 2);
      OP_LINE:  return 8'(ARG_BASE + 4);
      OP_RECT:  return 8'(ARG_BASE + 4);
      OP_BLIT:  return 8'(ARG_BASE + 10);
      default:  return 8'(ARG_BASE);
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of snapshotted commands. Flush may keep the head entry
// (keep_head) so a command already offered to the executor survives it.
module cmd_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
)(
  input  logic             phi2,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop, keep;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs; a flush swallows the push.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign keep    = keep_head & ~do_pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= rd_ptr + PW'(do_pop | keep);
      count  <= (PW+1)'(keep);
    end else begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= wr_ptr + PW'(do_push);
      count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage
  always_ff @(posedge phi2) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cpu_cmd_queue.sv
// CPU register window that stages graphics commands and queues them for the
// executor. Optional macro CMD_IRQ_EN adds the irq_n output and IRQ_PEND bit.
module cpu_cmd_queue
  import gfx_cmd_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int NUM_ARGS    = 11,
  parameter int QUEUE_DEPTH = 4
)(
  input  logic                  phi2,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  rw,
  input  logic                  ce0,
  input  logic                  ce1b,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_opcode,
  output logic [8*NUM_ARGS-1:0] cmd_args,
  input  logic                  exec_done,
  input  logic                  exec_error,
  input  logic [7:0]            result_0,
  input  logic [7:0]            result_1,
`ifdef CMD_IRQ_EN
  output logic                  irq_n,
`endif
  output logic [7:0]            mode_control
);
  localparam int TOP = 2**ADDR_W - 1;
  localparam int FW  = 8*(NUM_ARGS+1);

  logic                     sel, wr, rd, is_top, flush, trig, op_ok;
  logic                     push_req, trig_err, pop, full, empty, busy;
  logic                     err_set, ovf_set, status_rd, rd_top_q;
  logic                     err_q, ovf_q, irq_pend;
  logic [7:0]               opcode_q, trig_addr, status, rd_val;
  logic [NUM_ARGS-1:0][7:0] arg_q, args_next;
  logic [FW-1:0]            head;
  issue_state_e             state;

  assign sel       = ce0 & ~ce1b;
  assign wr        = sel & ~rw;
  assign rd        = sel & rw;
  assign is_top    = addr == ADDR_W'(TOP);
  assign flush     = wr & is_top & data_in[0];
  assign op_ok     = opcode_valid(opcode_q) && (int'(trigger_idx(opcode_q)) <= NUM_ARGS + 1);
  assign trig_addr = op_ok ? trigger_idx(opcode_q) : 8'(ARG_BASE);
  assign trig      = wr && (16'(addr) == 16'(trig_addr));
  assign push_req  = trig & op_ok;
  assign trig_err  = trig & ~op_ok;
  assign pop       = (state == S_OFFER) & cmd_ready;
  assign ovf_set   = push_req & ~flush & full & ~pop;
  assign err_set   = trig_err | ((state == S_WAIT) & exec_error);
  assign status_rd = rd & is_top & ~rd_top_q;
  assign busy      = (state != S_IDLE) | ~empty;
  assign status    = {~full, 2'b00, irq_pend, full, ovf_q, err_q, busy};

  // Staged args with this cycle's write folded in, so the trigger byte lands in the push
  always_comb begin
    args_next = arg_q;
    for (int i = 0; i < NUM_ARGS; i++)
      if (wr && addr == ADDR_W'(i + ARG_BASE)) args_next[i] = data_in;
  end

  // CPU read decode
  always_comb begin
    rd_val = 8'h00;
    if (addr == ADDR_W'(0))            rd_val = mode_control;
    else if (addr == ADDR_W'(1))       rd_val = opcode_q;
    else if (is_top)                   rd_val = status;
    else if (addr == ADDR_W'(TOP - 1)) rd_val = result_1;
    else if (addr == ADDR_W'(TOP - 2)) rd_val = result_0;
    else
      for (int i = 0; i < NUM_ARGS; i++)
        if (addr == ADDR_W'(i + ARG_BASE)) rd_val = arg_q[i];
  end

  cmd_fifo #(.WIDTH(FW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .phi2      (phi2),
    .reset_n   (reset_n),
    .push      (push_req),
    .pop       (pop),
    .flush     (flush),
    .keep_head (state == S_OFFER),
    .wdata     ({opcode_q, args_next}),
    .rdata     (head),
    .full      (full),
    .empty     (empty)
  );

  // Register window, read port and sticky status flags (set wins over clear)
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      mode_control <= 8'h00;
      opcode_q     <= 8'h00;
      arg_q        <= '0;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
      rd_top_q     <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (wr && addr == ADDR_W'(0)) mode_control <= data_in;
      if (wr && addr == ADDR_W'(1)) opcode_q     <= data_in;
      arg_q    <= args_next;
      if (rd) data_out <= rd_val;
      data_oe  <= rd;
      rd_top_q <= rd & is_top;
      err_q    <= err_set | (err_q & ~status_rd);
      ovf_q    <= ovf_set | (ovf_q & ~status_rd);
    end
  end

  // Issue FSM: offer FIFO head, pop on accept, wait for executor completion
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cmd_valid  <= 1'b0;
      cmd_opcode <= 8'h00;
      cmd_args   <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (!empty && !flush) begin
            state      <= S_OFFER;
            cmd_valid  <= 1'b1;
            cmd_opcode <= head[FW-1 -: 8];
            cmd_args   <= head[8*NUM_ARGS-1:0];
          end
        S_OFFER:
          if (cmd_ready) begin
            state     <= S_WAIT;
            cmd_valid <= 1'b0;
          end
        S_WAIT:
          if (exec_done || exec_error) state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_IRQ_EN
  // Interrupt pending: completion or new error/overflow, cleared by status read
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) irq_pend <= 1'b0;
    else irq_pend <= ((state == S_WAIT) & (exec_done | exec_error)) | err_set | ovf_set
                     | (irq_pend & ~status_rd);
  end
  assign irq_n = ~irq_pend;
`else
  assign irq_pend = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_cmd_queue.sv
// Self-checking bench for cpu_cmd_queue: register table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_cpu_cmd_queue;
  localparam int AW = 4, NA = 11, QD = 4;
  localparam logic [3:0] A_TOP = 4'd15;
`ifdef CMD_IRQ_EN
  localparam logic [7:0] IRQB = 8'h10;
`else
  localparam logic [7:0] IRQB = 8'h00;
`endif

  logic            phi2 = 0, reset_n = 0;
  logic [AW-1:0]   addr = '0;
  logic [7:0]      data_in = '0, data_out, mode_control, cmd_opcode;
  logic            data_oe, rw = 1, ce0 = 0, ce1b = 0;
  logic            cmd_valid, cmd_ready = 0, exec_done = 0, exec_error = 0;
  logic [8*NA-1:0] cmd_args;
  logic [7:0]      result_0 = 8'hA5, result_1 = 8'h3C;
`ifdef CMD_IRQ_EN
  logic            irq_n;
`endif

  cpu_cmd_queue #(.ADDR_W(AW), .NUM_ARGS(NA), .QUEUE_DEPTH(QD)) dut (
    .phi2(phi2), .reset_n(reset_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .rw(rw), .ce0(ce0), .ce1b(ce1b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_args(cmd_args), .exec_done(exec_done), .exec_error(exec_error),
    .result_0(result_0), .result_1(result_1),
`ifdef CMD_IRQ_EN
    .irq_n(irq_n),
`endif
    .mode_control(mode_control));

  always #5 phi2 = ~phi2;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge phi2); @(negedge phi2);
  endtask

  task automatic bus_idle();
    ce0 = 0; rw = 1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ce0 = 1; ce1b = 0; rw = 0; addr = a; data_in = d;
    cyc(); bus_idle();
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    ce0 = 1; ce1b = 0; rw = 1; addr = a;
    cyc(); v = data_out;
    chk("read_oe", data_oe, 1'b1);
    bus_idle();
  endtask

  task automatic rd_status(input string nm, input logic [7:0] exp);
    logic [7:0] v;
    rd(A_TOP, v);
    chk(nm, v, exp);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!cmd_valid && n < 10) begin cyc(); n++; end
    if (!cmd_valid) chk({nm, "_valid_timeout"}, 0, 1);
  endtask

  // Wait for an offer, check it, accept it (executor now busy with it)
  task automatic accept(input string nm, input logic [7:0] op, input logic [7:0] a1);
    wait_valid(nm);
    chk({nm, "_op"}, cmd_opcode, op);
    chk({nm, "_arg1"}, cmd_args[15:8], a1);
    cmd_ready = 1; cyc(); cmd_ready = 0;
    chk({nm, "_valid_drop"}, cmd_valid, 1'b0);
  endtask

  task automatic pulse_done();
    exec_done = 1; cyc(); exec_done = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; bus_idle(); cmd_ready = 0; exec_done = 0; exec_error = 0;
    cyc(); cyc(); reset_n = 1; cyc();
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic m_valid(input logic [7:0] op);
    return op <= 8'h05;
  endfunction

  function automatic logic [3:0] m_trig(input logic [7:0] op);
    case (op)
      8'h00: return 4'd3;
      8'h01: return 4'd2;
      8'h02: return 4'd4;
      8'h03: return 4'd6;
      8'h04: return 4'd6;
      8'h05: return 4'd12;
      default: return 4'd2;
    endcase
  endfunction

  typedef struct { logic [7:0] op; logic [8*NA-1:0] args; } cmd_t;

  typedef struct { logic wr; logic [3:0] a; logic [7:0] d; } vec_t;

  initial begin
    vec_t tbl[14];
    logic [7:0] v;
    tbl = '{'{1, 4'd0, 8'h5A}, '{0, 4'd0, 8'h5A}, '{1, 4'd1, 8'h05}, '{0, 4'd1, 8'h05},
            '{1, 4'd2, 8'hA1}, '{0, 4'd2, 8'hA1}, '{1, 4'd7, 8'hB2}, '{0, 4'd7, 8'hB2},
            '{1, 4'd11, 8'hC3}, '{0, 4'd11, 8'hC3}, '{0, 4'd13, 8'hA5}, '{0, 4'd14, 8'h3C},
            '{0, 4'd12, 8'h00}, '{1, 4'd0, 8'h0F}};

    do_reset();
    // Reset state
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_mode", mode_control, 8'h00);
`ifdef CMD_IRQ_EN
    chk("rst_irq_n", irq_n, 1'b1);
`endif
    rd_status("rst_status", 8'h80);

    // Register window table
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
        chk("tbl_wr_oe", data_oe, 1'b0);
      end else begin
        rd(tbl[i].a, v);
        chk($sformatf("tbl_rd_%0d", i), v, tbl[i].d);
      end
    end
    chk("tbl_mode", mode_control, 8'h0F);
    chk("tbl_no_push", cmd_valid, 1'b0);

    // Single PUTC: opcode 0, trigger on arg1
    wr(4'd1, 8'h00); wr(4'd3, 8'h41);
    accept("putc", 8'h00, 8'h41);
    pulse_done(); cyc();
`ifdef CMD_IRQ_EN
    chk("done_irq_n", irq_n, 1'b0);
`endif
    rd_status("putc_status", 8'h80 | IRQB);
`ifdef CMD_IRQ_EN
    cyc();
    chk("irq_cleared", irq_n, 1'b1);
`endif

    // Overflow: five triggers with executor stalled
    for (int k = 0; k < 5; k++) wr(4'd3, 8'h10 + 8'(k));
    rd_status("ovf_status", 8'h0D | IRQB);
    for (int k = 0; k < 4; k++) begin
      accept($sformatf("drain%0d", k), 8'h00, 8'h10 + 8'(k));
      pulse_done();
    end
    cyc(); cyc();
    chk("fifth_dropped", cmd_valid, 1'b0);
    rd_status("drain_status", 8'h80 | IRQB);

    // Invalid opcode: arg0 write flags ERROR, no push
    wr(4'd1, 8'h7F); wr(4'd2, 8'h11); cyc();
    chk("inv_no_push", cmd_valid, 1'b0);
    rd_status("inv_status1", 8'h82 | IRQB);
    cyc();
    rd_status("inv_status2", 8'h80);

    // exec_error in WAIT sets ERROR; exec_done in IDLE ignored
    wr(4'd1, 8'h00); wr(4'd3, 8'h01);
    accept("err", 8'h00, 8'h01);
    exec_error = 1; cyc(); exec_error = 0;
    rd_status("exec_err_status", 8'h82 | IRQB);
    cyc();
    pulse_done(); cyc();
    rd_status("idle_done_status", 8'h80);

    // Flush with three queued behind an in-flight command
    wr(4'd3, 8'h21);
    accept("flush_head", 8'h00, 8'h21);
    wr(4'd3, 8'h22); wr(4'd3, 8'h23); wr(4'd3, 8'h24);
    wr(A_TOP, 8'h01); cyc();
    rd_status("flush_busy", 8'h81);
    pulse_done(); cyc(); cyc(); cyc();
    chk("flush_empty", cmd_valid, 1'b0);
    rd_status("flush_status", 8'h80 | IRQB);

    // Reset in the middle of WAIT
    wr(4'd3, 8'h30);
    accept("rst_wait", 8'h00, 8'h30);
    do_reset();
    chk("rstw_valid", cmd_valid, 1'b0);
    chk("rstw_dout", data_out, 8'h00);
`ifdef CMD_IRQ_EN
    chk("rstw_irq_n", irq_n, 1'b1);
`endif
    rd_status("rstw_status", 8'h80);
    pulse_done();
    chk("rstw_no_offer", cmd_valid, 1'b0);

    // ---------------- randomized traffic vs model ----------------
    begin
      cmd_t q[$];
      cmd_t c;
      logic [7:0] m_op = 8'h00;
      logic [8*NA-1:0] m_args = '0;
      logic m_err = 0, m_ovf = 0, m_irq = 0, waiting = 0, last_rd = 0, rd_pend = 0;
      logic [7:0] rd_exp = 8'h00;
      int wcnt = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
        int sz;
        logic pop, fin, dn, er, e_set, o_set, stat_rd, mbusy, mfull;
        int r;
        if (rd_pend) begin chk("rand_status", data_out, rd_exp); rd_pend = 0; end
        sz = q.size();
        mbusy = (sz > 0) || waiting;
        mfull = sz == QD;
        chk("rand_valid_has_entry", cmd_valid && sz == 0, 1'b0);

        // executor side
        cmd_ready = cmd_valid && ($urandom_range(2) == 0);
        pop = cmd_valid && cmd_ready;
        dn = 0; er = 0; fin = 0;
        if (waiting) begin
          if (wcnt == 0) begin
            fin = 1;
            if ($urandom_range(3) == 0) er = 1; else dn = 1;
          end else wcnt--;
        end else if ($urandom_range(15) == 0) begin
          if ($urandom_range(1) == 0) dn = 1; else er = 1;
        end
        exec_done = dn; exec_error = er;
        if (pop) begin
          if (sz > 0) begin
            c = q.pop_front();
            chk("rand_pop_op", cmd_opcode, c.op);
            chk("rand_pop_args", cmd_args, c.args);
          end else chk("rand_pop_empty", 1'b1, 1'b0);
        end

        // CPU side
        e_set = waiting && er;
        o_set = 0; stat_rd = 0;
        ce1b = 0;
        r = last_rd ? 16 : $urandom_range(19);
        if (r < 3) begin
          logic [7:0] op;
          op = ($urandom_range(7) < 6) ? 8'($urandom_range(5)) : 8'($urandom);
          ce0 = 1; rw = 0; addr = 4'd1; data_in = op; m_op = op;
        end else if (r < 12) begin
          logic [3:0] a;
          logic [7:0] d;
          a = (r < 7) ? m_trig(m_op) : 4'($urandom_range(12, 2));
          d = 8'($urandom);
          ce0 = 1; rw = 0; addr = a; data_in = d;
          m_args[(int'(a) - 2)*8 +: 8] = d;
          if (a == m_trig(m_op)) begin
            if (!m_valid(m_op)) e_set = 1;
            else if (q.size() == QD) o_set = 1;
            else begin c.op = m_op; c.args = m_args; q.push_back(c); end
          end
        end else if (r < 15) begin
          ce0 = 1; rw = 1; addr = A_TOP; stat_rd = 1;
          rd_exp = {~mfull, 2'b00, m_irq & (IRQB != 0), mfull, m_ovf, m_err, mbusy};
          rd_pend = 1;
        end else if (r == 15) begin
          ce0 = 1; rw = 0; addr = A_TOP; data_in = 8'h01;
          if (cmd_valid && !pop && q.size() > 0) begin
            c = q[0]; q.delete(); q.push_back(c);
          end else q.delete();
        end else begin
          // deselected bus activity must have no effect
          ce0 = $urandom_range(1); ce1b = 1; rw = 0;
          addr = 4'($urandom); data_in = 8'($urandom);
        end
        last_rd = stat_rd;

        m_err = e_set | (m_err & ~stat_rd);
        m_ovf = o_set | (m_ovf & ~stat_rd);
        m_irq = (waiting & (dn | er)) | e_set | o_set | (m_irq & ~stat_rd);

        cyc();
`ifdef CMD_IRQ_EN
        chk("rand_irq_n", irq_n, ~m_irq);
`endif
        if (fin) waiting = 0;
        if (pop) begin waiting = 1; wcnt = $urandom_range(4); end
      end
      bus_idle(); cmd_ready = 0; exec_done = 0; exec_error = 0;
      if (rd_pend) chk("rand_status_last", data_out, rd_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
